// File: rtl/ser_pkg.sv
// ser_pkg: shared state type, default width and counter-width helper for the bit serializer
package ser_pkg;
   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
   localparam int WIDTH_DEF = 8;
   function automatic int CNT_W(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction
endpackage

// File: rtl/ser_hold_reg.sv
// ser_hold_reg: one-word holding register that parks the next word while the current one shifts
module ser_hold_reg import ser_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] hold,
   output logic             hold_full
);
   // load and drain never coincide: load needs an empty register, drain needs a full one
   always_ff @(posedge clk)
      if (reset) begin
         hold      <= '0;
         hold_full <= 1'b0;
      end else begin
         if (load) hold <= din;
         hold_full <= load ? 1'b1 : (drain ? 1'b0 : hold_full);
      end
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end feeding the 1101 sequence detector
module bit_serializer import ser_pkg::*; #(
   parameter int   WIDTH     = WIDTH_DEF,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x_out,
   output logic             x_valid,
   output logic             frame_start,
   output logic             busy
);
   localparam int CW = CNT_W(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   state_t state, state_n;
   logic [WIDTH-1:0] sh, sh_n, hold;
   logic [CW-1:0] cnt, cnt_n;
   logic hold_full, xfer, last, hold_ld, drain;
   assign in_ready = !hold_full && !reset;
   assign xfer     = in_valid && in_ready;
   assign last     = (state == ST_SHIFT) && (cnt == LAST);
   assign hold_ld  = xfer && (state == ST_SHIFT) && !last;
   assign drain    = last && hold_full;
   ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk       (clk),
      .reset     (reset),
      .load      (hold_ld),
      .drain     (drain),
      .din       (in_data),
      .hold      (hold),
      .hold_full (hold_full)
   );
   // next word source at the last-bit edge: held word first, then a same-edge bypass, else idle
   always_comb begin
      state_n = state;
      sh_n    = sh;
      cnt_n   = cnt;
      if (state == ST_IDLE) begin
         if (xfer) begin
            state_n = ST_SHIFT;
            sh_n    = in_data;
            cnt_n   = '0;
         end
      end else if (!last) begin
         sh_n  = MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
         cnt_n = cnt + 1'b1;
      end else begin
         cnt_n = '0;
         if (hold_full) sh_n = hold;
         else if (xfer) sh_n = in_data;
         else state_n = ST_IDLE;
      end
   end
   // state, shift register and bit counter
   always_ff @(posedge clk)
      if (reset) begin
         state <= ST_IDLE;
         sh    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         sh    <= sh_n;
         cnt   <= cnt_n;
      end
   assign x_valid     = (state == ST_SHIFT);
   assign x_out       = x_valid ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT;
   assign frame_start = x_valid && (cnt == '0);
   assign busy        = x_valid || hold_full;
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: randomized and directed checks of bit_serializer against a bit-queue model
module tb_bit_serializer;
   localparam int W = 8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [W-1:0] in_data = '0;
   logic in_valid = 1'b0;
   logic in_ready, x_out, x_valid, frame_start, busy;
   logic [W-1:0] l_data = '0;
   logic l_valid = 1'b0;
   logic l_ready, l_x_out, l_x_valid, l_frame_start, l_busy;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit q[$];
   int acc_t[$];
   bit cap_on = 1'b0;
   bit cap_o[$], cap_v[$], cap_r[$];

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .x_out(x_out), .x_valid(x_valid), .frame_start(frame_start), .busy(busy));

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
      .clk(clk), .reset(reset), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
      .x_out(l_x_out), .x_valid(l_x_valid), .frame_start(l_frame_start), .busy(l_busy));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic m_ready();
      return !reset && q.size() <= W;
   endfunction

   // model: a queue of bits still to be emitted; the front is the bit on the wire this cycle
   always @(posedge clk) begin
      logic acc;
      cyc++;
      acc = in_valid && m_ready();
      if (reset) q.delete();
      else begin
         if (q.size() > 0) void'(q.pop_front());
         if (acc) begin
            for (int i = 0; i < W; i++) q.push_back(in_data[W-1-i]);
            acc_t.push_back(cyc);
         end
      end
   end

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      logic ev;
      ev = q.size() > 0;
      chk("x_valid", x_valid, ev);
      chk("x_out", x_out, ev ? q[0] : 1'b0);
      chk("frame_start", frame_start, ev && (q.size() % W == 0));
      chk("busy", busy, ev);
      chk("in_ready", in_ready, m_ready());
      if (cap_on) begin
         cap_o.push_back(x_out);
         cap_v.push_back(x_valid);
         cap_r.push_back(in_ready);
      end
   end

   task automatic cap_start();
      cap_o.delete(); cap_v.delete(); cap_r.delete(); acc_t.delete();
      cap_on = 1'b1;
   endtask

   task automatic cap_check(input string nm, input logic [31:0] exp_bits, input int exp_n, input int exp_rdy_lo);
      logic [31:0] bits = '0;
      int nv = 0, runs = 0, rlo = 0;
      cap_on = 1'b0;
      foreach (cap_v[i]) begin
         if (cap_v[i]) begin
            bits = {bits[30:0], cap_o[i]};
            nv++;
            if (i == 0 || !cap_v[i-1]) runs++;
         end
         if (!cap_r[i]) rlo++;
      end
      chk({nm, "_bits"}, bits, exp_bits);
      chk({nm, "_nvalid"}, nv, exp_n);
      chk({nm, "_runs"}, runs, 1);
      chk({nm, "_ready_lo"}, rlo, exp_rdy_lo);
   endtask

   // present words back to back with in_valid held, advancing on each model-predicted transfer
   task automatic stream(input logic [W-1:0] w[$]);
      foreach (w[k]) begin
         bit ok = 1'b0;
         in_valid = 1'b1;
         in_data = w[k];
         for (int t = 0; t < 50 && !ok; t++) begin
            ok = m_ready();
            @(posedge clk); #1;
         end
         if (!ok) chk("stream_timeout", 0, 1);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      logic [W-1:0] a, b, c;
      logic [9:0] lo, lv, lf;
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_x_valid", x_valid, 0);
      chk("rst_x_out", x_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1);
      @(posedge clk); #1;
      // single word
      cap_start();
      stream('{8'hD0});
      repeat (12) @(posedge clk); #1;
      cap_check("single", 32'hD0, 8, 0);
      // back to back
      cap_start();
      stream('{8'hDD, 8'hB6});
      repeat (20) @(posedge clk); #1;
      cap_check("b2b", 32'hDDB6, 16, 7);
      chk("b2b_acc_gap", acc_t[1] - acc_t[0], 1);
      // bypass on the last-bit edge
      cap_start();
      stream('{8'hDD});
      repeat (7) @(posedge clk); #1;
      stream('{8'h0D});
      repeat (12) @(posedge clk); #1;
      cap_check("bypass", 32'hDD0D, 16, 0);
      chk("bypass_acc_gap", acc_t[1] - acc_t[0], 8);
      // backpressure with three queued words
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      cap_start();
      stream('{a, b, c});
      repeat (20) @(posedge clk); #1;
      cap_check("bp", {8'h00, a, b, c}, 24, 14);
      chk("bp_transfers", acc_t.size(), 3);
      chk("bp_gap1", acc_t[1] - acc_t[0], 1);
      chk("bp_gap2", acc_t[2] - acc_t[1], 8);
      // reset at bit 4 while a second word is held
      stream('{8'hFF, 8'hFF});
      repeat (3) @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", in_ready, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_x_valid", x_valid, 0);
      chk("mid_rst_x_out", x_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready_after", in_ready, 1);
      cap_on = 1'b1; cap_v.delete(); cap_o.delete(); cap_r.delete();
      repeat (20) @(negedge clk);
      cap_on = 1'b0;
      chk("mid_rst_no_words", cap_v.sum() with (int'(item)), 0);
      // LSB-first instance
      @(posedge clk); #1;
      chk("lsb_ready", l_ready, 1);
      l_valid = 1'b1; l_data = 8'h0B;
      @(posedge clk); #1 l_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         lo = {lo[8:0], l_x_out}; lv = {lv[8:0], l_x_valid}; lf = {lf[8:0], l_frame_start};
      end
      chk("lsb_bits", lo, 10'b1101000000);
      chk("lsb_valid", lv, 10'b1111111100);
      chk("lsb_fs", lf, 10'b1000000000);
      chk("lsb_busy_idle", l_busy, 0);
      // randomized traffic with occasional reset
      @(posedge clk); #1;
      for (int i = 0; i < 3000; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data = W'($urandom);
         reset = ($urandom_range(0, 199) == 0);
         @(posedge clk); #1;
      end
      reset = 1'b0; in_valid = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
